pipe_hazard_ctrl: RTL and testbench

Parametrised in-order pipeline backbone for the ARM core. It carries per-instruction control and payload from the ID stage through DEPTH downstream stages (EXE, MEM, WB by default). It detects RAW hazards against in-flight destinations and inserts bubbles on a stall or a taken branch. It replaces the hard-wired zero hazard/freeze/flush ties and the fixed-width per-stage registers in the top level with one configurable block, and adds an optional forwarding mode and a stall counter.

---
 rtl/pipe_hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// In-order pipeline backbone: carries ID control/payload through DEPTH stages,
// detects RAW hazards against in-flight writers and inserts bubbles on stall or branch.
module pipe_hazard_ctrl #(
   parameter int PAYLOAD_W = 32,
   parameter int RA_W      = 4,
   parameter int DEPTH     = 3,
   parameter int FWD_EN    = 0
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_id_valid,
   input  logic [PAYLOAD_W-1:0]       i_id_payload,
   input  logic [RA_W-1:0]            i_id_src1,
   input  logic [RA_W-1:0]            i_id_src2,
   input  logic                       i_id_two_src,
   input  logic                       i_id_wb_en,
   input  logic                       i_id_mem_read,
   input  logic [RA_W-1:0]            i_id_dest,
   input  logic                       i_branch_taken,
   output logic                       o_hazard,
   output logic                       o_flush,
   output logic [DEPTH-1:0]           o_stg_valid,
   output logic [DEPTH-1:0]           o_stg_wb_en,
   output logic [DEPTH-1:0]           o_stg_mem_read,
   output logic [DEPTH*RA_W-1:0]      o_stg_dest,
   output logic [DEPTH*PAYLOAD_W-1:0] o_stg_payload,
   output logic [15:0]                o_stall_count
);

   // With forwarding only a load sitting in EXE can still starve its consumer;
   // without it every writer up to (but not including) WB is a hazard source.
   localparam int CHK = (FWD_EN != 0) ? 1 : DEPTH - 1;

   logic [DEPTH-1:0]                r_valid;
   logic [DEPTH-1:0]                r_wb_en;
   logic [DEPTH-1:0]                r_mem_read;
   logic [DEPTH-1:0][RA_W-1:0]      r_dest;
   logic [DEPTH-1:0][PAYLOAD_W-1:0] r_payload;
   logic [15:0]                     r_stall_count;

   logic [DEPTH-1:0]     w_src1_hit;
   logic [DEPTH-1:0]     w_src2_hit;
   logic                 w_raw_hazard;
   logic                 w_hazard;
   logic                 w_accept;
   logic                 w_ld_wb_en;
   logic                 w_ld_mem_read;
   logic [RA_W-1:0]      w_ld_dest;
   logic [PAYLOAD_W-1:0] w_ld_payload;

   always_comb begin
      w_src1_hit = '0;
      w_src2_hit = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_src1_hit[k] = r_valid[k] & r_wb_en[k] & (r_dest[k] == i_id_src1);
         w_src2_hit[k] = r_valid[k] & r_wb_en[k] & (r_dest[k] == i_id_src2) & i_id_two_src;
      end
   end

   always_comb begin
      w_raw_hazard = 1'b0;
      for (int k = 0; k < CHK; k++) begin
         if (w_src1_hit[k] | w_src2_hit[k]) begin
            w_raw_hazard = 1'b1;
         end
      end
      if (FWD_EN != 0) begin
         w_raw_hazard = w_raw_hazard & r_mem_read[0];
      end
   end

   // A taken branch squashes the ID instruction, so it overrides any stall.
   assign w_hazard = i_id_valid & w_raw_hazard & ~i_branch_taken;
   assign w_accept = i_id_valid & ~w_hazard & ~i_branch_taken;

   always_comb begin
      w_ld_wb_en    = 1'b0;
      w_ld_mem_read = 1'b0;
      w_ld_dest     = '0;
      w_ld_payload  = '0;
      if (w_accept) begin
         w_ld_wb_en    = i_id_wb_en;
         w_ld_mem_read = i_id_mem_read;
         w_ld_dest     = i_id_dest;
         w_ld_payload  = i_id_payload;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid    <= '0;
         r_wb_en    <= '0;
         r_mem_read <= '0;
         r_dest     <= '0;
         r_payload  <= '0;
      end else begin
         r_valid    <= {r_valid[DEPTH-2:0], w_accept};
         r_wb_en    <= {r_wb_en[DEPTH-2:0], w_ld_wb_en};
         r_mem_read <= {r_mem_read[DEPTH-2:0], w_ld_mem_read};
         r_dest     <= {r_dest[DEPTH-2:0], w_ld_dest};
         r_payload  <= {r_payload[DEPTH-2:0], w_ld_payload};
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stall_count <= '0;
      end else if (w_hazard && (r_stall_count != 16'hFFFF)) begin
         r_stall_count <= r_stall_count + 16'd1;
      end
   end

   assign o_hazard       = w_hazard;
   assign o_flush        = i_branch_taken;
   assign o_stg_valid    = r_valid;
   assign o_stg_wb_en    = r_wb_en;
   assign o_stg_mem_read = r_mem_read;
   assign o_stg_dest     = r_dest;
   assign o_stg_payload  = r_payload;
   assign o_stall_count  = r_stall_count;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: three pipe_hazard_ctrl configurations share one stimulus stream
// and are compared cycle by cycle against an instruction-level reference model.
module tb_pipe_hazard_ctrl;

   localparam int PW = 16;
   localparam int RW = 4;

   logic clk = 1'b0;
   logic rstN, idValid, idTwoSrc, idWbEn, idMemRead, branchTaken;
   logic [PW-1:0] idPayload;
   logic [RW-1:0] idSrc1, idSrc2, idDest;

   logic aHz, aFl, bHz, bFl, cHz, cFl;
   logic [2:0] aV, aWb, aMr, bV, bWb, bMr;
   logic [7:0] cV, cWb, cMr;
   logic [11:0] aDest, bDest;
   logic [31:0] cDest;
   logic [47:0] aPay, bPay;
   logic [127:0] cPay;
   logic [15:0] aCnt, bCnt, cCnt;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.PAYLOAD_W(PW), .RA_W(RW), .DEPTH(3), .FWD_EN(0)) dutA (
      .i_clk(clk), .i_rst_n(rstN), .i_id_valid(idValid), .i_id_payload(idPayload),
      .i_id_src1(idSrc1), .i_id_src2(idSrc2), .i_id_two_src(idTwoSrc), .i_id_wb_en(idWbEn),
      .i_id_mem_read(idMemRead), .i_id_dest(idDest), .i_branch_taken(branchTaken),
      .o_hazard(aHz), .o_flush(aFl), .o_stg_valid(aV), .o_stg_wb_en(aWb),
      .o_stg_mem_read(aMr), .o_stg_dest(aDest), .o_stg_payload(aPay), .o_stall_count(aCnt));

   pipe_hazard_ctrl #(.PAYLOAD_W(PW), .RA_W(RW), .DEPTH(3), .FWD_EN(1)) dutB (
      .i_clk(clk), .i_rst_n(rstN), .i_id_valid(idValid), .i_id_payload(idPayload),
      .i_id_src1(idSrc1), .i_id_src2(idSrc2), .i_id_two_src(idTwoSrc), .i_id_wb_en(idWbEn),
      .i_id_mem_read(idMemRead), .i_id_dest(idDest), .i_branch_taken(branchTaken),
      .o_hazard(bHz), .o_flush(bFl), .o_stg_valid(bV), .o_stg_wb_en(bWb),
      .o_stg_mem_read(bMr), .o_stg_dest(bDest), .o_stg_payload(bPay), .o_stall_count(bCnt));

   pipe_hazard_ctrl #(.PAYLOAD_W(PW), .RA_W(RW), .DEPTH(8), .FWD_EN(0)) dutC (
      .i_clk(clk), .i_rst_n(rstN), .i_id_valid(idValid), .i_id_payload(idPayload),
      .i_id_src1(idSrc1), .i_id_src2(idSrc2), .i_id_two_src(idTwoSrc), .i_id_wb_en(idWbEn),
      .i_id_mem_read(idMemRead), .i_id_dest(idDest), .i_branch_taken(branchTaken),
      .o_hazard(cHz), .o_flush(cFl), .o_stg_valid(cV), .o_stg_wb_en(cWb),
      .o_stg_mem_read(cMr), .o_stg_dest(cDest), .o_stg_payload(cPay), .o_stall_count(cCnt));

   typedef struct packed {
      logic         hz;
      logic         fl;
      logic [15:0]  cnt;
      logic [7:0]   v;
      logic [7:0]   wb;
      logic [7:0]   mr;
      logic [31:0]  dest;
      logic [127:0] pay;
   } exp_t;

   typedef struct packed {
      exp_t [2:0] e;
   } frame_t;

   typedef struct packed {
      logic          v;
      logic          wb;
      logic          mr;
      logic [RW-1:0] dest;
      logic [PW-1:0] pay;
   } ent_t;

   frame_t expQ[$];
   frame_t monF;
   exp_t   act [3];
   ent_t   pipe [3][8];
   logic [15:0] cnt [3];
   int checks = 0;
   int errors = 0;

   // Gather each DUT's outputs into the common wide expectation layout.
   always_comb begin
      for (int i = 0; i < 3; i++) act[i] = '0;
      act[0].hz = aHz; act[0].fl = aFl; act[0].cnt = aCnt;
      act[0].v = {5'b0, aV}; act[0].wb = {5'b0, aWb}; act[0].mr = {5'b0, aMr};
      act[0].dest = {20'b0, aDest}; act[0].pay = {80'b0, aPay};
      act[1].hz = bHz; act[1].fl = bFl; act[1].cnt = bCnt;
      act[1].v = {5'b0, bV}; act[1].wb = {5'b0, bWb}; act[1].mr = {5'b0, bMr};
      act[1].dest = {20'b0, bDest}; act[1].pay = {80'b0, bPay};
      act[2].hz = cHz; act[2].fl = cFl; act[2].cnt = cCnt;
      act[2].v = cV; act[2].wb = cWb; act[2].mr = cMr;
      act[2].dest = cDest; act[2].pay = cPay;
   end

   function automatic int depthOf(int i);
      return (i == 2) ? 8 : 3;
   endfunction

   function automatic bit fwdOf(int i);
      return (i == 1);
   endfunction

   // An ID instruction must wait if it reads a register that an in-flight
   // instruction has not yet made available (any writer before WB, or only an
   // EXE-stage load when forwarding is present). A taken branch cancels the wait.
   function automatic logic modelHazard(int i);
      int  window = fwdOf(i) ? 1 : depthOf(i) - 1;
      logic raw = 1'b0;
      for (int k = 0; k < window; k++) begin
         ent_t en = pipe[i][k];
         if (en.v && en.wb && ((en.dest == idSrc1) || (idTwoSrc && en.dest == idSrc2))
             && (!fwdOf(i) || en.mr))
            raw = 1'b1;
      end
      return idValid && raw && !branchTaken;
   endfunction

   function automatic exp_t modelExp(int i);
      exp_t e = '0;
      e.hz  = modelHazard(i);
      e.fl  = branchTaken;
      e.cnt = cnt[i];
      for (int k = 0; k < depthOf(i); k++) begin
         e.v[k]             = pipe[i][k].v;
         e.wb[k]            = pipe[i][k].wb;
         e.mr[k]            = pipe[i][k].mr;
         e.dest[k*RW +: RW] = pipe[i][k].dest;
         e.pay[k*PW +: PW]  = pipe[i][k].pay;
      end
      return e;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 3; i++) begin
         for (int k = 0; k < 8; k++) pipe[i][k] = '0;
         cnt[i] = 16'd0;
      end
   endtask

   task automatic modelStep(int i);
      logic hz = modelHazard(i);
      for (int k = depthOf(i) - 1; k > 0; k--) pipe[i][k] = pipe[i][k-1];
      if (idValid && !hz && !branchTaken)
         pipe[i][0] = {1'b1, idWbEn, idMemRead, idDest, idPayload};
      else
         pipe[i][0] = '0;
      if (hz && cnt[i] != 16'hFFFF) cnt[i] = cnt[i] + 16'd1;
   endtask

   task automatic checkOutput(input string name, input logic [183:0] actV, input logic [183:0] expV);
      checks++;
      if (actV !== expV) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actV, expV);
      end
   endtask

   // One clock cycle: drive ID between edges, queue the expected view of that
   // cycle, then advance the model across the rising edge.
   task automatic applyStimulus(input logic r, input logic v, input logic [PW-1:0] pay,
                                input logic [RW-1:0] s1, input logic [RW-1:0] s2,
                                input logic two, input logic wb, input logic mr,
                                input logic [RW-1:0] dest, input logic br);
      frame_t fr;
      @(negedge clk);
      rstN = r; idValid = v; idPayload = pay; idSrc1 = s1; idSrc2 = s2;
      idTwoSrc = two; idWbEn = wb; idMemRead = mr; idDest = dest; branchTaken = br;
      if (!r) modelReset();
      for (int i = 0; i < 3; i++) fr.e[i] = modelExp(i);
      expQ.push_back(fr);
      @(posedge clk);
      if (r) for (int i = 0; i < 3; i++) modelStep(i);
      #1;
   endtask

   // Monitor: the DUT presents a full state every cycle; compare it mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (expQ.size() > 0) begin
            monF = expQ.pop_front();
            for (int i = 0; i < 3; i++) begin
               checkOutput($sformatf("ctrl[%0d]", i),
                           {act[i].hz, act[i].fl, act[i].cnt},
                           {monF.e[i].hz, monF.e[i].fl, monF.e[i].cnt});
               checkOutput($sformatf("stages[%0d]", i),
                           {act[i].v, act[i].wb, act[i].mr, act[i].dest, act[i].pay},
                           {monF.e[i].v, monF.e[i].wb, monF.e[i].mr, monF.e[i].dest, monF.e[i].pay});
            end
         end
      end
   end

   initial begin
      rstN = 1'b0; idValid = 1'b0; idPayload = '0; idSrc1 = '0; idSrc2 = '0;
      idTwoSrc = 1'b0; idWbEn = 1'b0; idMemRead = 1'b0; idDest = '0; branchTaken = 1'b0;

      applyStimulus(1'b0, 1'b0, 16'h0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      applyStimulus(1'b0, 1'b0, 16'h0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      checkOutput("resetIdle", {aV, aCnt, cV, cCnt}, '0);

      // Writer of R1 followed by a reader of R1.
      applyStimulus(1'b1, 1'b1, 16'h1111, 4'd3, 4'd4, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0);
      applyStimulus(1'b1, 1'b1, 16'h2222, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      checkOutput("rawBubble", aV[0], 1'b0);
      applyStimulus(1'b1, 1'b1, 16'h2222, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      applyStimulus(1'b1, 1'b1, 16'h2222, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      checkOutput("rawStallCount", aCnt, 16'd2);
      checkOutput("rawReaderStage0", {aV[0], aPay[15:0]}, {1'b1, 16'h2222});

      // Fill with independent instructions, then reset between edges.
      applyStimulus(1'b1, 1'b1, 16'h3331, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd8, 1'b0);
      applyStimulus(1'b1, 1'b1, 16'h3332, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0);
      applyStimulus(1'b1, 1'b1, 16'h3333, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd10, 1'b0);
      checkOutput("filledValid", aV, 3'b111);
      applyStimulus(1'b0, 1'b1, 16'h3334, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd11, 1'b0);
      checkOutput("midResetValid", {aV, cV}, '0);
      checkOutput("midResetCount", {aCnt, cCnt}, '0);
      applyStimulus(1'b1, 1'b1, 16'h4444, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0);
      checkOutput("resetResume", {aV, aPay[15:0]}, {3'b001, 16'h4444});

      // Load-use with forwarding: one stall; plain writer: none.
      applyStimulus(1'b0, 1'b0, 16'h0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      applyStimulus(1'b1, 1'b1, 16'h5555, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd2, 1'b0);
      applyStimulus(1'b1, 1'b1, 16'h6666, 4'd7, 4'd2, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      applyStimulus(1'b1, 1'b1, 16'h6666, 4'd7, 4'd2, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      checkOutput("loadUseCount", bCnt, 16'd1);
      applyStimulus(1'b0, 1'b0, 16'h0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      applyStimulus(1'b1, 1'b1, 16'h5556, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0);
      applyStimulus(1'b1, 1'b1, 16'h6667, 4'd7, 4'd2, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      applyStimulus(1'b1, 1'b1, 16'h6667, 4'd7, 4'd2, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      checkOutput("fwdNoStallCount", bCnt, 16'd0);

      // Single-source reader whose unused src2 matches an in-flight dest.
      applyStimulus(1'b0, 1'b0, 16'h0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      applyStimulus(1'b1, 1'b1, 16'h7777, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0);
      applyStimulus(1'b1, 1'b1, 16'h8888, 4'd5, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      checkOutput("singleSrcAccept", {aV[0], cV[0], aCnt, cCnt}, {2'b11, 32'd0});

      // Branch taken while a RAW hit is pending.
      applyStimulus(1'b0, 1'b0, 16'h0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      applyStimulus(1'b1, 1'b1, 16'h9999, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0);
      applyStimulus(1'b1, 1'b1, 16'hAAAA, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
      checkOutput("branchBubble", {aV[0], cV[0], aCnt, cCnt}, {2'b00, 32'd0});

      // Randomised traffic over a small register file to provoke many hits.
      for (int n = 0; n < 3000; n++) begin
         applyStimulus($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0, 16'($urandom),
                       4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                       $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                       $urandom_range(0, 2) == 0, 4'($urandom_range(0, 3)),
                       $urandom_range(0, 7) == 0);
      end

      // Self-dependent load stream keeps the deep pipe stalled long enough to saturate.
      applyStimulus(1'b0, 1'b0, 16'h0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      for (int n = 0; n < 75000; n++) begin
         applyStimulus(1'b1, 1'b1, 16'(n), 4'd5, 4'd0, 1'b0, 1'b1, 1'b1, 4'd5, 1'b0);
      end
      checkOutput("saturated", cCnt, 16'hFFFF);
      for (int n = 0; n < 50; n++) begin
         applyStimulus(1'b1, 1'b1, 16'(n), 4'd5, 4'd0, 1'b0, 1'b1, 1'b1, 4'd5, 1'b0);
      end
      checkOutput("saturatedHold", cCnt, 16'hFFFF);

      #30;
      if (expQ.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
